// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter between a single-cycle unit (A) and a multi-cycle unit (B).
// A normally wins. B is promoted to priority after STARVE_LIMIT stalled cycles.
// The accepted request is registered and drives the register file write port
// one cycle later. An 8-entry pending-write scoreboard is also maintained.
module reg_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [39:0] a_wr,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [39:0] b_wr,
  input  logic        sb_set_en,
  input  logic [2:0]  sb_set_addr0,
  input  logic [2:0]  sb_set_addr1,
  input  logic        flush,
  output logic        reg_write_en,
  output logic [1:0]  write_mode,
  output logic [2:0]  reg_write_addr_0,
  output logic [2:0]  reg_write_addr_1,
  output logic [15:0] data_in_0,
  output logic [15:0] data_in_1,
  output logic [7:0]  busy,
  output logic        b_priority
);

  typedef enum logic [0:0] {StNormal, StBPri} state_e;

  localparam logic [1:0] LimitM1 = 2'(STARVE_LIMIT - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  busy_q, busy_d;
  logic        wen_q, wen_d;
  logic [1:0]  mode_q, mode_d;
  logic [2:0]  addr0_q, addr0_d;
  logic [2:0]  addr1_q, addr1_d;
  logic [15:0] data0_q, data0_d;
  logic [15:0] data1_q, data1_d;

  logic        a_acc, b_acc, any_acc;
  logic [39:0] acc_wr;

  // Ready generation: the priority side is ready whenever not flushing/reset;
  // the other side only when the priority side is idle.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst && !flush) begin
      if (state_q == StNormal) begin
        a_ready = 1'b1;
        b_ready = !a_valid;
      end else begin
        b_ready = 1'b1;
        a_ready = !b_valid;
      end
    end
  end

  assign a_acc   = a_valid && a_ready;
  assign b_acc   = b_valid && b_ready;
  assign any_acc = a_acc || b_acc;
  assign acc_wr  = a_acc ? a_wr : b_wr;

  // Next commit: copy the accepted payload, otherwise drive an idle (all-zero) write.
  always_comb begin
    wen_d   = 1'b0;
    mode_d  = 2'b00;
    addr0_d = 3'd0;
    addr1_d = 3'd0;
    data0_d = 16'd0;
    data1_d = 16'd0;
    if (any_acc) begin
      wen_d   = (acc_wr[39:38] != 2'b00);
      mode_d  = acc_wr[39:38];
      addr0_d = acc_wr[37:35];
      addr1_d = acc_wr[34:32];
      data0_d = acc_wr[31:16];
      data1_d = acc_wr[15:0];
    end
  end

  // Scoreboard: clear destinations of the accepted write, then apply sets so set wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = 8'd0;
    end else begin
      if (any_acc && acc_wr[39:38] != 2'b00) begin
        busy_d[acc_wr[37:35]] = 1'b0;
        if (acc_wr[39:38] == 2'b11 && acc_wr[34:32] != 3'd0) begin
          busy_d[acc_wr[34:32]] = 1'b0;
        end
      end
      if (sb_set_en) begin
        busy_d[sb_set_addr0] = 1'b1;
        if (sb_set_addr1 != 3'd0) begin
          busy_d[sb_set_addr1] = 1'b1;
        end
      end
    end
  end

  // Starvation counter and priority state.
  always_comb begin
    state_d = state_q;
    cnt_d   = 2'd0;
    if (flush) begin
      state_d = StNormal;
    end else if (state_q == StNormal) begin
      if (b_valid && !b_ready) begin
        if (cnt_q == LimitM1) begin
          state_d = StBPri;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
    end else if (b_acc) begin
      state_d = StNormal;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StNormal;
      cnt_q   <= 2'd0;
      busy_q  <= 8'd0;
      wen_q   <= 1'b0;
      mode_q  <= 2'b00;
      addr0_q <= 3'd0;
      addr1_q <= 3'd0;
      data0_q <= 16'd0;
      data1_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      wen_q   <= wen_d;
      mode_q  <= mode_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  assign reg_write_en     = wen_q;
  assign write_mode       = mode_q;
  assign reg_write_addr_0 = addr0_q;
  assign reg_write_addr_1 = addr1_q;
  assign data_in_0        = data0_q;
  assign data_in_1        = data1_q;
  assign busy             = busy_q;
  assign b_priority       = (state_q == StBPri);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural model of the arbitration rules.
module tb_reg_wb_arbiter;

  localparam int Limit = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [39:0] a_wr, b_wr;
  logic        sb_set_en, flush;
  logic [2:0]  sb_set_addr0, sb_set_addr1;
  logic        reg_write_en, b_priority;
  logic [1:0]  write_mode;
  logic [2:0]  reg_write_addr_0, reg_write_addr_1;
  logic [15:0] data_in_0, data_in_1;
  logic [7:0]  busy;

  reg_wb_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk              (clk),
    .rst              (rst),
    .a_valid          (a_valid),
    .a_ready          (a_ready),
    .a_wr             (a_wr),
    .b_valid          (b_valid),
    .b_ready          (b_ready),
    .b_wr             (b_wr),
    .sb_set_en        (sb_set_en),
    .sb_set_addr0     (sb_set_addr0),
    .sb_set_addr1     (sb_set_addr1),
    .flush            (flush),
    .reg_write_en     (reg_write_en),
    .write_mode       (write_mode),
    .reg_write_addr_0 (reg_write_addr_0),
    .reg_write_addr_1 (reg_write_addr_1),
    .data_in_0        (data_in_0),
    .data_in_1        (data_in_1),
    .busy             (busy),
    .b_priority       (b_priority)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  bit        m_bpri;
  int        m_stall;       // consecutive stalled B cycles in normal mode
  bit [7:0]  m_busy;
  bit        m_en;
  bit [39:0] m_wr;          // expected committed payload (zero when idle)
  bit        m_ar, m_br;    // expected readies this cycle
  bit        m_aacc, m_bacc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bpri = 0; m_stall = 0; m_busy = '0; m_en = 0; m_wr = '0;
  endtask

  function automatic bit [7:0] clear_dests(input bit [7:0] b, input bit [39:0] w);
    bit [7:0] r = b;
    case (w[39:38])
      2'b00: ;
      2'b11: begin
        r[w[37:35]] = 0;
        if (w[34:32] != 0) r[w[34:32]] = 0;
      end
      default: r[w[37:35]] = 0;
    endcase
    return r;
  endfunction

  // One clock cycle: check readies/outputs against the model, then advance the model.
  task automatic step();
    #2;
    if (rst || flush) begin
      m_ar = 0; m_br = 0;
    end else if (m_bpri) begin
      m_br = 1; m_ar = !b_valid;
    end else begin
      m_ar = 1; m_br = !a_valid;
    end
    chk("a_ready", 64'(a_ready), 64'(m_ar));
    chk("b_ready", 64'(b_ready), 64'(m_br));
    chk("reg_write_en", 64'(reg_write_en), 64'(m_en));
    chk("write_mode", 64'(write_mode), 64'(m_wr[39:38]));
    chk("addr0", 64'(reg_write_addr_0), 64'(m_wr[37:35]));
    chk("addr1", 64'(reg_write_addr_1), 64'(m_wr[34:32]));
    chk("data0", 64'(data_in_0), 64'(m_wr[31:16]));
    chk("data1", 64'(data_in_1), 64'(m_wr[15:0]));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("b_priority", 64'(b_priority), 64'(m_bpri));
    @(posedge clk);
    m_aacc = a_valid && m_ar;
    m_bacc = b_valid && m_br;
    if (rst) begin
      model_reset();
    end else begin
      m_wr = m_aacc ? a_wr : (m_bacc ? b_wr : 40'd0);
      m_en = (m_aacc || m_bacc) && (m_wr[39:38] != 2'b00);
      if (flush) begin
        m_busy = '0; m_stall = 0; m_bpri = 0;
      end else begin
        if (m_aacc || m_bacc) m_busy = clear_dests(m_busy, m_wr);
        if (sb_set_en) begin
          m_busy[sb_set_addr0] = 1;
          if (sb_set_addr1 != 0) m_busy[sb_set_addr1] = 1;
        end
        if (m_bpri) begin
          if (m_bacc) m_bpri = 0;
          m_stall = 0;
        end else if (b_valid && !m_br) begin
          m_stall++;
          if (m_stall == Limit) begin
            m_bpri = 1; m_stall = 0;
          end
        end else begin
          m_stall = 0;
        end
      end
    end
    #1;
  endtask

  function automatic logic [39:0] pkt(input logic [1:0] md, input logic [2:0] a0,
                                      input logic [2:0] a1, input logic [15:0] d0,
                                      input logic [15:0] d1);
    return {md, a0, a1, d0, d1};
  endfunction

  initial begin
    rst = 1; a_valid = 0; b_valid = 0; a_wr = '0; b_wr = '0;
    sb_set_en = 0; sb_set_addr0 = 0; sb_set_addr1 = 0; flush = 0;
    model_reset();
    #12;
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_b_ready", 64'(b_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wen", 64'(reg_write_en), 64'd0);
    rst = 0;
    #1;
    step();

    // A-only write, mode 11.
    a_valid = 1; a_wr = pkt(2'b11, 3'd2, 3'd3, 16'h1234, 16'hABCD);
    step();
    a_valid = 0;
    chk("a_only_en", 64'(reg_write_en), 64'd1);
    chk("a_only_data", 64'({data_in_0, data_in_1}), 64'h1234ABCD);
    step();

    // A and B contend: B starves for Limit cycles, then gets priority.
    a_valid = 1; b_valid = 1;
    a_wr = pkt(2'b01, 3'd1, 3'd0, 16'h0A0A, 16'h0000);
    b_wr = pkt(2'b10, 3'd7, 3'd0, 16'h0B0B, 16'h0000);
    for (int i = 0; i < Limit; i++) step();
    chk("starve_bpri", 64'(b_priority), 64'd1);
    step();
    b_valid = 0;
    chk("starve_back_normal", 64'(b_priority), 64'd0);
    step();
    a_valid = 0;
    step();

    // Scoreboard set then cleared by a mode-11 B commit.
    sb_set_en = 1; sb_set_addr0 = 3'd5; sb_set_addr1 = 3'd6;
    step();
    sb_set_en = 0;
    chk("sb56_set", 64'(busy[6:5]), 64'd3);
    b_valid = 1; b_wr = pkt(2'b11, 3'd5, 3'd6, 16'h5555, 16'h6666);
    step();
    b_valid = 0;
    chk("sb56_clr", 64'(busy[6:5]), 64'd0);
    step();

    // Set wins over clear on the same edge.
    sb_set_en = 1; sb_set_addr0 = 3'd4; sb_set_addr1 = 3'd0;
    step();
    a_valid = 1; a_wr = pkt(2'b01, 3'd4, 3'd0, 16'h4444, 16'h0);
    step();
    a_valid = 0; sb_set_en = 0;
    chk("set_wins", 64'(busy[4]), 64'd1);
    step();

    // Fill scoreboard, force B priority, then flush.
    sb_set_en = 1;
    for (int i = 0; i < 4; i++) begin
      sb_set_addr0 = 3'(2 * i); sb_set_addr1 = 3'(2 * i + 1);
      step();
    end
    sb_set_en = 0;
    a_valid = 1; b_valid = 1;
    a_wr = pkt(2'b00, 3'd3, 3'd0, 16'h0, 16'h0);
    b_wr = pkt(2'b10, 3'd2, 3'd0, 16'h0, 16'h0);
    for (int i = 0; i < Limit; i++) step();
    chk("flush_pre_busy", 64'(busy), 64'hFF);
    chk("flush_pre_bpri", 64'(b_priority), 64'd1);
    flush = 1;
    step();
    flush = 0; a_valid = 0; b_valid = 0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_bpri", 64'(b_priority), 64'd0);
    step();

    // Reset in the middle of a commit.
    a_valid = 1; a_wr = pkt(2'b10, 3'd6, 3'd0, 16'hBEEF, 16'h0);
    step();
    a_valid = 0;
    rst = 1;
    #1;
    model_reset();
    chk("midrst_en", 64'(reg_write_en), 64'd0);
    chk("midrst_data", 64'(data_in_0), 64'd0);
    step();
    rst = 0;
    step();
    step();

    // Random traffic honouring hold-until-accepted.
    for (int i = 0; i < 400; i++) begin
      if (!a_valid || m_aacc) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_wr = 40'({$urandom(), $urandom()});
      end
      if (!b_valid || m_bacc) begin
        b_valid = ($urandom_range(0, 1) != 0);
        b_wr = 40'({$urandom(), $urandom()});
      end
      sb_set_en = ($urandom_range(0, 3) == 0);
      sb_set_addr0 = 3'($urandom());
      sb_set_addr1 = 3'($urandom());
      flush = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
